// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Writeback stage driving the register-file write port. Retiring
//   instructions arrive from the memory stage. The stage selects the write data
//   (PC+4, ALU result or load data), stalls for variable-latency loads, steers
//   faulting instructions to the XP register and drops writes to R31.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_*              memory-stage handshake and instruction fields
//   mem_rvalid/rdata  load data return
//   wb_*              registered register-file write side
//   load_pending/rc   hazard information for decode
//   err_timeout       one-cycle pulse when a load times out
//   retired_count     wrapping count of retired instructions
module regfile_writeback #(
   parameter int XP_REG      = 30,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc_plus4,
   input  logic [31:0]      in_alu,
   input  logic [4:0]       in_rc,
   input  logic             in_werf,
   input  logic [1:0]       in_wdsel,
   input  logic             in_exc,
   input  logic             mem_rvalid,
   input  logic [31:0]      mem_rdata,
   output logic [4:0]       wb_rc,
   output logic             wb_werf,
   output logic [31:0]      wb_wd,
   output logic [4:0]       wb_xpreg,
   output logic             wb_wasel,
   output logic             load_pending,
   output logic [4:0]       load_rc,
   output logic             err_timeout,
   output logic [CNT_W-1:0] retired_count
);

   localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   typedef struct packed {
      logic        werf;
      logic        wasel;
      logic [4:0]  rc;
      logic [31:0] wd;
   } wb_t;

   state_t      state_q, state_d;
   wb_t         wb_q, wb_d;
   logic        pend_q, pend_d;
   logic [4:0]  lrc_q, lrc_d;
   logic [31:0] pc_q, pc_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic        tmo_q, tmo_d;
   logic        retire;
   logic [CNT_W-1:0] rcnt_q;
   logic        accept;

   // Held low during reset so nothing is accepted before the stage is up.
   assign in_ready = rst_n & (state_q == IDLE);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      wb_d    = wb_q;
      wb_d.werf = 1'b0;
      pend_d  = pend_q;
      lrc_d   = lrc_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      retire  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_exc) begin
                  // Fault wins over everything: PC+4 goes to XP, no memory wait.
                  wb_d   = '{werf: 1'b1, wasel: 1'b1, rc: in_rc, wd: in_pc_plus4};
                  retire = 1'b1;
               end else if (in_wdsel == 2'd2 && in_werf) begin
                  state_d = WAIT_MEM;
                  pend_d  = 1'b1;
                  lrc_d   = in_rc;
                  pc_d    = in_pc_plus4;
                  cnt_d   = '0;
               end else begin
                  // wdsel 3 behaves as ALU. A non-writing load lands here too.
                  wb_d.werf  = in_werf & (in_rc != 5'd31);
                  wb_d.wasel = 1'b0;
                  wb_d.rc    = in_rc;
                  wb_d.wd    = (in_wdsel == 2'd0) ? in_pc_plus4 : in_alu;
                  retire     = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid) begin
               // Data beats a simultaneous timeout.
               wb_d    = '{werf: (lrc_q != 5'd31), wasel: 1'b0, rc: lrc_q, wd: mem_rdata};
               pend_d  = 1'b0;
               state_d = IDLE;
               retire  = 1'b1;
            end else if (cnt_q == TMO_LAST) begin
               wb_d    = '{werf: 1'b1, wasel: 1'b1, rc: lrc_q, wd: pc_q};
               tmo_d   = 1'b1;
               pend_d  = 1'b0;
               state_d = IDLE;
               retire  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_q   <= '0;
         pend_q <= 1'b0;
         lrc_q  <= '0;
         pc_q   <= '0;
         cnt_q  <= '0;
         tmo_q  <= 1'b0;
         rcnt_q <= '0;
      end else begin
         wb_q   <= wb_d;
         pend_q <= pend_d;
         lrc_q  <= lrc_d;
         pc_q   <= pc_d;
         cnt_q  <= cnt_d;
         tmo_q  <= tmo_d;
         if (retire) rcnt_q <= rcnt_q + 1'b1;
      end
   end

   assign wb_werf       = wb_q.werf;
   assign wb_wasel      = wb_q.wasel;
   assign wb_rc         = wb_q.rc;
   assign wb_wd         = wb_q.wd;
   assign wb_xpreg      = 5'(XP_REG);
   assign load_pending  = pend_q;
   assign load_rc       = lrc_q;
   assign err_timeout   = tmo_q;
   assign retired_count = rcnt_q;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc_plus4;
   logic [31:0] in_alu;
   logic [4:0]  in_rc;
   logic        in_werf;
   logic [1:0]  in_wdsel;
   logic        in_exc;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  wb_rc;
   logic        wb_werf;
   logic [31:0] wb_wd;
   logic [4:0]  wb_xpreg;
   logic        wb_wasel;
   logic        load_pending;
   logic [4:0]  load_rc;
   logic        err_timeout;
   logic [31:0] retired_count;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_writeback #(.XP_REG(30), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc_plus4(in_pc_plus4), .in_alu(in_alu), .in_rc(in_rc),
      .in_werf(in_werf), .in_wdsel(in_wdsel), .in_exc(in_exc),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_rc(wb_rc), .wb_werf(wb_werf), .wb_wd(wb_wd), .wb_xpreg(wb_xpreg),
      .wb_wasel(wb_wasel), .load_pending(load_pending), .load_rc(load_rc),
      .err_timeout(err_timeout), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rc, input logic [1:0] sel, input logic werf,
                        input logic exc, input logic [31:0] pc, input logic [31:0] alu);
      in_valid    = 1'b1;
      in_rc       = rc;
      in_wdsel    = sel;
      in_werf     = werf;
      in_exc      = exc;
      in_pc_plus4 = pc;
      in_alu      = alu;
   endtask

   task automatic write_chk(input string tag, input logic wasel, input logic [4:0] rc,
                            input logic [31:0] wd, input logic [31:0] cnt);
      chk({tag, ".werf"},  32'(wb_werf), 32'd1);
      chk({tag, ".wasel"}, 32'(wb_wasel), 32'(wasel));
      if (!wasel) chk({tag, ".rc"}, 32'(wb_rc), 32'(rc));
      chk({tag, ".wd"},    wb_wd, wd);
      chk({tag, ".cnt"},   retired_count, cnt);
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_pc_plus4 = '0; in_alu = '0; in_rc = '0;
      in_werf = 1'b0; in_wdsel = '0; in_exc = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0;

      // reset state
      #12;
      chk("rst.ready", 32'(in_ready), 32'd0);
      chk("rst.werf",  32'(wb_werf), 32'd0);
      chk("rst.wd",    wb_wd, 32'd0);
      chk("rst.pend",  32'(load_pending), 32'd0);
      chk("rst.cnt",   retired_count, 32'd0);
      chk("rst.tmo",   32'(err_timeout), 32'd0);
      chk("xpreg",     32'(wb_xpreg), 32'd30);
      rst_n = 1'b1;
      #1;
      chk("rst.ready_rel", 32'(in_ready), 32'd1);
      tick();

      // ALU write then back-to-back
      drive(5'd5, 2'd1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_00AA);
      tick();
      write_chk("alu0", 1'b0, 5'd5, 32'hAA, 32'd1);
      drive(5'd6, 2'd1, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_00BB);
      tick();
      write_chk("alu1", 1'b0, 5'd6, 32'hBB, 32'd2);
      in_valid = 1'b0;
      tick();
      chk("alu.idle_werf", 32'(wb_werf), 32'd0);
      chk("alu.idle_cnt", retired_count, 32'd2);

      // PC+4 select and wdsel=3 as ALU
      drive(5'd4, 2'd0, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_1111);
      tick();
      write_chk("pc4", 1'b0, 5'd4, 32'h44, 32'd3);
      drive(5'd8, 2'd3, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_2222);
      tick();
      write_chk("sel3", 1'b0, 5'd8, 32'h2222, 32'd4);

      // R31 suppressed but retired
      drive(5'd31, 2'd1, 1'b1, 1'b0, 32'h0000_004C, 32'h0000_3333);
      tick();
      chk("r31.werf", 32'(wb_werf), 32'd0);
      chk("r31.cnt",  retired_count, 32'd5);

      // Load with latency
      drive(5'd7, 2'd2, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
      tick();
      in_valid = 1'b0;
      chk("ld.werf0", 32'(wb_werf), 32'd0);
      chk("ld.pend",  32'(load_pending), 32'd1);
      chk("ld.lrc",   32'(load_rc), 32'd7);
      chk("ld.ready", 32'(in_ready), 32'd0);
      tick();
      tick();
      chk("ld.pend2",  32'(load_pending), 32'd1);
      chk("ld.ready2", 32'(in_ready), 32'd0);
      chk("ld.cnt_wait", retired_count, 32'd5);
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      write_chk("ld.wr", 1'b0, 5'd7, 32'hDEAD_BEEF, 32'd6);
      chk("ld.pend_clr", 32'(load_pending), 32'd0);
      tick();
      chk("ld.ready_back", 32'(in_ready), 32'd1);
      chk("ld.werf_pulse", 32'(wb_werf), 32'd0);

      // rvalid in IDLE ignored
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      mem_rvalid = 1'b0;
      chk("idle_rv.werf", 32'(wb_werf), 32'd0);
      chk("idle_rv.cnt",  retired_count, 32'd6);

      // Exception overrides load
      drive(5'd3, 2'd2, 1'b1, 1'b1, 32'h0000_0104, 32'h0);
      tick();
      in_valid = 1'b0; in_exc = 1'b0;
      write_chk("exc", 1'b1, 5'd3, 32'h104, 32'd7);
      chk("exc.pend",  32'(load_pending), 32'd0);
      chk("exc.ready", 32'(in_ready), 32'd1);

      // Non-writing load retires immediately
      drive(5'd12, 2'd2, 1'b0, 1'b0, 32'h0000_0108, 32'h0);
      tick();
      in_valid = 1'b0;
      chk("ldnw.werf",  32'(wb_werf), 32'd0);
      chk("ldnw.ready", 32'(in_ready), 32'd1);
      chk("ldnw.cnt",   retired_count, 32'd8);

      // Timeout
      drive(5'd9, 2'd2, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("tmo.wait_err",   32'(err_timeout), 32'd0);
         chk("tmo.wait_ready", 32'(in_ready), 32'd0);
         tick();
      end
      chk("tmo.early_err", 32'(err_timeout), 32'd0);
      tick();
      chk("tmo.err", 32'(err_timeout), 32'd1);
      write_chk("tmo.wr", 1'b1, 5'd9, 32'h200, 32'd9);
      chk("tmo.ready", 32'(in_ready), 32'd1);
      chk("tmo.pend",  32'(load_pending), 32'd0);
      tick();
      chk("tmo.err_pulse",  32'(err_timeout), 32'd0);
      chk("tmo.werf_pulse", 32'(wb_werf), 32'd0);

      // rvalid in the final cycle wins over timeout
      drive(5'd10, 2'd2, 1'b1, 1'b0, 32'h0000_0210, 32'h0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("tmo2.pend", 32'(load_pending), 32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_rvalid = 1'b0;
      chk("tmo2.err", 32'(err_timeout), 32'd0);
      write_chk("tmo2.wr", 1'b0, 5'd10, 32'h1234_5678, 32'd10);

      // Async reset during WAIT_MEM
      drive(5'd11, 2'd2, 1'b1, 1'b0, 32'h0000_0220, 32'h0);
      tick();
      in_valid = 1'b0;
      tick();
      chk("ar.pend_before", 32'(load_pending), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.pend",  32'(load_pending), 32'd0);
      chk("ar.lrc",   32'(load_rc), 32'd0);
      chk("ar.cnt",   retired_count, 32'd0);
      chk("ar.ready", 32'(in_ready), 32'd0);
      chk("ar.wd",    wb_wd, 32'd0);
      #3 rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_rvalid = 1'b0;
      chk("ar.rv_werf", 32'(wb_werf), 32'd0);
      chk("ar.rv_cnt",  retired_count, 32'd0);
      chk("ar.rv_ready", 32'(in_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
